// File: rtl/input_setup.sv
// Fetches a 2x2 matrix (row-major, 4 words) and streams it skewed into a 2x2 systolic array, then drains.
// Latency: first strobe 1 cycle after start, first array input 6 cycles after start; optional INPUT_SETUP_SATURATE_EN clamps oversized words.
module input_setup #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 6,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [12:0]       base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic [DATA_W-1:0] a_in1,
    output logic [DATA_W-1:0] a_in2,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, FETCH, STREAM, DRAIN, FIN} state_t;

    localparam logic [7:0] DRAIN_LAST = 8'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] base_q, base_sel;
    logic [DATA_W-1:0] elem [4];

    logic              rd_en_nxt, valid_nxt, busy_nxt, done_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic [DATA_W-1:0] a1_nxt, a2_nxt;
    logic [DATA_W-1:0] word_val;
    logic              unused_bits;

    assign unused_bits = ^{base_addr[12:ADDR_W], mem_rd_data};

`ifdef INPUT_SETUP_SATURATE_EN
    assign word_val = ((mem_rd_data >> DATA_W) != 32'd0) ? '1 : mem_rd_data[DATA_W-1:0];
`else
    assign word_val = mem_rd_data[DATA_W-1:0];
`endif

    // During IDLE the address is taken straight from the port so the first strobe can be registered at acceptance.
    assign base_sel = (state == IDLE) ? base_addr[ADDR_W-1:0] : base_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                    cnt_nxt   = 8'd0;
                end
            end
            FETCH: begin
                if (cnt == 8'd4) begin
                    state_nxt = STREAM;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            STREAM: begin
                if (cnt == 8'd2) begin
                    state_nxt = (DRAIN_CYCLES == 0) ? FIN : DRAIN;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = FIN;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            FIN: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Outputs are derived from the next state so that they appear registered in the cycle they belong to.
    always_comb begin
        rd_en_nxt   = (state_nxt == FETCH) && (cnt_nxt < 8'd4);
        rd_addr_nxt = rd_en_nxt ? base_sel + ADDR_W'(cnt_nxt) : '0;
        valid_nxt   = (state_nxt == STREAM) || (state_nxt == DRAIN);
        busy_nxt    = (state_nxt != IDLE);
        done_nxt    = (state_nxt == FIN);
        a1_nxt      = '0;
        a2_nxt      = '0;
        if (state_nxt == STREAM) begin
            case (cnt_nxt)
                8'd0:    a1_nxt = elem[0];
                8'd1: begin
                    a1_nxt = elem[1];
                    a2_nxt = elem[2];
                end
                8'd2:    a2_nxt = elem[3];
                default: a1_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            base_q      <= '0;
            elem[0]     <= '0;
            elem[1]     <= '0;
            elem[2]     <= '0;
            elem[3]     <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            a_in1       <= '0;
            a_in2       <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            base_q      <= base_sel;
            if (state == FETCH && cnt != 8'd0)
                elem[2'(cnt - 8'd1)] <= word_val;
            mem_rd_en   <= rd_en_nxt;
            mem_rd_addr <= rd_addr_nxt;
            a_in1       <= a1_nxt;
            a_in2       <= a2_nxt;
            valid       <= valid_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: doc/input_setup.md
INPUT_SETUP -- requirements
Module: input_setup

Interface
REQ-001: Parameter DATA_W, default 16, width of each systolic-array row input.
REQ-002: Parameter ADDR_W, default 6, unified-memory address width (64 words).
REQ-003: Parameter DRAIN_CYCLES, default 2, zero-input cycles after the last matrix element.
REQ-004: clk  input  1  single clock; all state updates on the rising edge.
REQ-005: reset  input  1  asynchronous, active-low reset.
REQ-006: start  input  1  one-cycle request to fetch and stream one 2x2 input matrix.
REQ-007: base_addr  input  13  unified-memory word address of element a11 (13-bit immediate field of the instruction).
REQ-008: mem_rd_en  output  1  unified-memory read strobe.
REQ-009: mem_rd_addr  output  ADDR_W  unified-memory read address.
REQ-010: mem_rd_data  input  32  read data, valid exactly one cycle after the strobe.
REQ-011: a_in1  output  DATA_W  skewed input to the top-left PE row.
REQ-012: a_in2  output  DATA_W  skewed input to the bottom-left PE row.
REQ-013: valid  output  1  a_in1/a_in2 carry a live array input this cycle.
REQ-014: busy  output  1  block is between start acceptance and done.
REQ-015: done  output  1  one-cycle pulse after the final drain cycle.

Function
REQ-016: FSM states are IDLE, FETCH, STREAM, DRAIN and FIN; IDLE is the reset state.
REQ-017: start is sampled only in IDLE; start while busy is ignored and has no side effects.
REQ-018: start sampled at edge T latches base_addr[ADDR_W-1:0] and enters FETCH; busy is high from cycle T+1 through the done cycle inclusive.
REQ-019: FETCH issues mem_rd_en in cycles T+1..T+4 at addresses base, base+1, base+2 and base+3 (modulo 2^ADDR_W); mem_rd_en is low in every other cycle.
REQ-020: Row-major storage: a11 at base, a12 at base+1, a21 at base+2, a22 at base+3.
REQ-021: Each returned word is captured one cycle after its strobe; the element value is mem_rd_data[DATA_W-1:0], with overflow handling per REQ-031.
REQ-022: FETCH lasts 5 cycles (T+1..T+5); STREAM occupies T+6..T+8.
REQ-023: STREAM output pairs (a_in1,a_in2) are (a11,0), (a12,a21), (0,a22) in T+6, T+7 and T+8 respectively.
REQ-024: DRAIN occupies the next DRAIN_CYCLES cycles with (0,0).
REQ-025: valid is high for every STREAM and DRAIN cycle and low otherwise.
REQ-026: a_in1 and a_in2 are driven 0 whenever valid is low.
REQ-027: FIN asserts done for exactly one cycle (T+9+DRAIN_CYCLES), then returns to IDLE; a start sampled in that done cycle is ignored.
REQ-028: All outputs are registered; no combinational path from start or mem_rd_data to any output.

Reset
REQ-029: Asserting reset forces IDLE immediately, independent of clk, and clears the latched address and captured elements.
REQ-030: Every output is 0 while reset is asserted; reset asserted mid-FETCH, STREAM or DRAIN aborts the transfer with no done pulse, and no stale data is emitted after release.

Configuration
REQ-031: Macro INPUT_SETUP_SATURATE_EN controls overflow handling of mem_rd_data.
  - Defined: any word with nonzero bits above DATA_W-1 is clamped to 2^DATA_W-1.
  - Undefined: the word is truncated to its low DATA_W bits.

Verification
REQ-032: mem[15..18]=11,12,21,22, base_addr=15, start -> reads 15..18, then (11,0),(12,21),(0,22),(0,0),(0,0) with valid high for 5 cycles, then one done pulse.
REQ-033: base_addr=62, mem[62,63,0,1]=1,2,3,4 -> read addresses 62,63,0,1; outputs (1,0),(2,3),(0,4),(0,0),(0,0).
REQ-034: start pulsed again at T+3 and in the done cycle -> both ignored, exactly one 5-cycle valid burst per accepted start.
REQ-035: reset asserted at T+7 -> all outputs 0 at once, no done pulse; a new start after release streams correctly.
REQ-036: mem[base]=0x0001_0005 -> a11 = 0xFFFF with INPUT_SETUP_SATURATE_EN defined, 0x0005 without.
